keypad_encoder: RTL and testbench

Scans a 4x4 matrix keypad, synchronises and debounces the row lines, and drives the `trigger`/`mode`/`num` command interface consumed by `controlunit`. It is the transmitter end of that interface: each debounced digit, `*` or `#` press produces exactly one single-cycle `trigger` with a stable `num`, and the A–D keys select `mode`. It sits between the board keypad pins and `controlunit` in the alarm clock top level.

---
 rtl/keypad_encoder_if.sv | 10 +
 rtl/keypad_encoder.sv | 191 +++++++++++++++++++
 tb/tb_keypad_encoder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_encoder_if.sv
// Command interface from the keypad encoder to the control unit:
// a mode selector plus a key code qualified by a single-cycle trigger.
interface keypad_encoder_if;
    logic [1:0] mode;
    logic [3:0] num;
    logic       trigger;

    modport master (output mode, output num, output trigger);
    modport slave  (input  mode, input  num, input  trigger);
endinterface

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner with row synchronisation, press/release
// debouncing and a registered trigger/mode/num command output.
module keypad_encoder #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 8
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    keypad_encoder_if.master cmd
);

    // One counter serves the scan slot, the press debounce and the release debounce.
    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_SCAN         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_EMIT         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    // Key map lookup: returns {is_mode_key, mode_value[1:0], code[3:0]}.
    function automatic logic [6:0] decode_key(input logic [1:0] r, input logic [1:0] c);
        logic [6:0] res;
        case ({r, c})
            4'd0:    res = {1'b0, 2'd0, 4'h1};
            4'd1:    res = {1'b0, 2'd0, 4'h2};
            4'd2:    res = {1'b0, 2'd0, 4'h3};
            4'd3:    res = {1'b1, 2'd1, 4'h0};   // A: set time
            4'd4:    res = {1'b0, 2'd0, 4'h4};
            4'd5:    res = {1'b0, 2'd0, 4'h5};
            4'd6:    res = {1'b0, 2'd0, 4'h6};
            4'd7:    res = {1'b1, 2'd2, 4'h0};   // B: set alarm
            4'd8:    res = {1'b0, 2'd0, 4'h7};
            4'd9:    res = {1'b0, 2'd0, 4'h8};
            4'd10:   res = {1'b0, 2'd0, 4'h9};
            4'd11:   res = {1'b1, 2'd3, 4'h0};   // C: alarm enable
            4'd12:   res = {1'b0, 2'd0, 4'hA};   // *: cancel
            4'd13:   res = {1'b0, 2'd0, 4'h0};
            4'd14:   res = {1'b0, 2'd0, 4'hB};   // #: enter
            4'd15:   res = {1'b1, 2'd0, 4'h0};   // D: normal
            default: res = {1'b0, 2'd0, 4'h0};
        endcase
        return res;
    endfunction

    // Lowest-numbered active (low) row; only meaningful when some row is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        if (rows[0] == 1'b0) begin
            idx = 2'd0;
        end else if (rows[1] == 1'b0) begin
            idx = 2'd1;
        end else if (rows[2] == 1'b0) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    state_t        state_r,   state_s;
    logic [CW-1:0] cnt_r,     cnt_s;
    logic [1:0]    col_idx_r, col_idx_s;
    logic [1:0]    row_idx_r, row_idx_s;
    logic [3:0]    col_r,     col_s;
    logic [1:0]    mode_r,    mode_s;
    logic [3:0]    num_r,     num_s;
    logic          trigger_r, trigger_s;
    logic [3:0]    sync1_r;
    logic [3:0]    rs_r;
    logic [6:0]    key_s;

    // Two-flop synchroniser for the asynchronous row lines (idle is all high).
    always_ff @(posedge system_clk) begin
        if (reset) begin
            sync1_r <= 4'hF;
            rs_r    <= 4'hF;
        end else begin
            sync1_r <= row;
            rs_r    <= sync1_r;
        end
    end

    // Next-state and next-output logic for the scan/debounce/emit/release FSM.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        col_idx_s = col_idx_r;
        row_idx_s = row_idx_r;
        mode_s    = mode_r;
        num_s     = num_r;
        trigger_s = 1'b0;
        key_s     = decode_key(row_idx_r, col_idx_r);
        case (state_r)
            ST_SCAN: begin
                if (cnt_r == SLOT_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (rs_r != 4'hF) begin
                        row_idx_s = lowest_low(rs_r);
                        state_s   = ST_DEBOUNCE;
                    end else begin
                        col_idx_s = col_idx_r + 2'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (rs_r[row_idx_r] == 1'b0) begin
                    if (cnt_r == DB_LAST) begin
                        cnt_s   = CNT_ZERO;
                        state_s = ST_EMIT;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    // Bounce: give up on this key and move on to the next column.
                    cnt_s     = CNT_ZERO;
                    col_idx_s = col_idx_r + 2'd1;
                    state_s   = ST_SCAN;
                end
            end
            ST_EMIT: begin
                if (key_s[6]) begin
                    mode_s = key_s[5:4];
                end else begin
                    trigger_s = 1'b1;
                    num_s     = key_s[3:0];
                end
                cnt_s   = CNT_ZERO;
                state_s = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (rs_r == 4'hF) begin
                    if (cnt_r == DB_LAST) begin
                        cnt_s     = CNT_ZERO;
                        col_idx_s = 2'd0;
                        state_s   = ST_SCAN;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            default: begin
                cnt_s     = CNT_ZERO;
                col_idx_s = 2'd0;
                state_s   = ST_SCAN;
            end
        endcase
        col_s = ~(4'b0001 << col_idx_s);
    end

    // State, counters and all outputs are registered together.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            state_r   <= ST_SCAN;
            cnt_r     <= CNT_ZERO;
            col_idx_r <= 2'd0;
            row_idx_r <= 2'd0;
            col_r     <= 4'b1110;
            mode_r    <= 2'd0;
            num_r     <= 4'h0;
            trigger_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            col_idx_r <= col_idx_s;
            row_idx_r <= row_idx_s;
            col_r     <= col_s;
            mode_r    <= mode_s;
            num_r     <= num_s;
            trigger_r <= trigger_s;
        end
    end

    assign col         = col_r;
    assign cmd.mode    = mode_r;
    assign cmd.num     = num_r;
    assign cmd.trigger = trigger_r;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: a keypad matrix model drives the
// rows from the scanned columns; expectations come from the key map text,
// the scan-slot arithmetic and a record of every trigger pulse.
module tb_keypad_encoder;

    logic       system_clk = 1'b0;
    logic       reset      = 1'b1;
    logic [3:0] row;
    logic [3:0] col;

    keypad_encoder_if cmd();

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .cmd        (cmd.master)
    );

    always #5 system_clk = ~system_clk;

    // Pressed-key matrix, index = row*4 + col.
    bit pressed [16];

    // Passive keypad: a row reads low when a pressed key sits on a driven-low column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && (col[c] === 1'b0)) row[r] = 1'b0;
            end
        end
    end

    int cyc = 0;
    always @(posedge system_clk) cyc <= cyc + 1;

    // Record of trigger pulses: cycle index and code, sampled just after each edge.
    int         trig_cyc_q [$];
    logic [3:0] trig_num_q [$];
    always @(posedge system_clk) begin
        #1;
        if (cmd.trigger === 1'b1) begin
            trig_cyc_q.push_back(cyc);
            trig_num_q.push_back(cmd.num);
        end
    end

    string keymap = "123A456B789C*0#D";

    int         checks = 0;
    int         errors = 0;
    int         rel;
    logic [1:0] exp_mode = 2'd0;
    logic [3:0] exp_num  = 4'h0;

    function automatic bit is_mode_key(int k);
        byte ch = keymap[k];
        return (ch >= "A") && (ch <= "D");
    endfunction

    function automatic logic [3:0] key_code(int k);
        byte ch = keymap[k];
        if (ch >= "0" && ch <= "9") return 4'(ch - "0");
        if (ch == "*") return 4'hA;
        if (ch == "#") return 4'hB;
        return 4'h0;
    endfunction

    // A->1, B->2, C->3, D->0
    function automatic logic [1:0] key_mode(int k);
        byte ch = keymap[k];
        return 2'((ch - "A" + 1) % 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge system_clk);
    endtask

    // Two reset cycles, check the reset state, release; rel = cycle before first live edge.
    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        exp_mode = 2'd0;
        exp_num  = 4'h0;
        chk("reset_col",     32'(col),         32'(4'b1110));
        chk("reset_mode",    32'(cmd.mode),    32'(exp_mode));
        chk("reset_num",     32'(cmd.num),     32'(exp_num));
        chk("reset_trigger", 32'(cmd.trigger), 32'(1'b0));
        reset = 1'b0;
        rel   = cyc;
    endtask

    // Key held through reset: detect lands on the last cycle of its column's slot.
    task automatic press_after_reset(input int k, input int hold);
        int base = trig_num_q.size();
        int r0;
        pressed[k] = 1'b1;
        do_reset();
        r0 = rel;
        tick(hold);
        pressed[k] = 1'b0;
        tick(40);
        if (is_mode_key(k)) begin
            exp_mode = key_mode(k);
            chk("modekey_pulses", 32'(trig_num_q.size() - base), 32'd0);
            chk("modekey_mode",   32'(cmd.mode), 32'(exp_mode));
            chk("modekey_num",    32'(cmd.num),  32'(exp_num));
        end else begin
            exp_num = key_code(k);
            chk("press_pulses", 32'(trig_num_q.size() - base), 32'd1);
            if (trig_num_q.size() > base) begin
                chk("press_num",     32'(trig_num_q[base]), 32'(exp_num));
                chk("press_latency", 32'(trig_cyc_q[base]), 32'(r0 + 4 * ((k % 4) + 1) + 9));
            end
            chk("press_num_held", 32'(cmd.num),  32'(exp_num));
            chk("press_mode",     32'(cmd.mode), 32'(exp_mode));
        end
    endtask

    // Press and release with no alignment to the scan phase.
    task automatic tap(input int k, input int hold);
        pressed[k] = 1'b1;
        tick(hold);
        pressed[k] = 1'b0;
        tick(40);
        if (is_mode_key(k)) begin
            exp_mode = key_mode(k);
        end else begin
            exp_num = key_code(k);
        end
    endtask

    // Pulse count since base, and the code of the last pulse when one is expected.
    task automatic check_pulses(input string tag, input int base, input int n);
        chk(tag, 32'(trig_num_q.size() - base), 32'(n));
        if (n > 0 && trig_num_q.size() >= base + n) begin
            chk({tag, "_num"}, 32'(trig_num_q[base+n-1]), 32'(exp_num));
        end
        chk({tag, "_mode"}, 32'(cmd.mode), 32'(exp_mode));
    endtask

    initial begin
        int base;
        int hp;
        int g;
        for (int i = 0; i < 16; i++) pressed[i] = 1'b0;
        @(negedge system_clk);

        // Reset with idle keypad, then the column drive rotates every 4 cycles.
        do_reset();
        for (int j = 1; j <= 16; j++) begin
            logic [3:0] e;
            tick(1);
            e = ~(4'b0001 << ((j / 4) % 4));
            chk("col_rotate", 32'(col), 32'(e));
            chk("idle_trigger", 32'(cmd.trigger), 32'(1'b0));
        end

        // Single long press of 5, then a few random keys.
        press_after_reset(5, 200);
        for (int n = 0; n < 5; n++) begin
            press_after_reset(int'($urandom_range(0, 15)), int'($urandom_range(30, 120)));
        end

        // Mode key B, then enter.
        do_reset();
        base = trig_num_q.size();
        tap(7, 60);
        check_pulses("mode_b", base, 0);
        tap(14, 60);
        check_pulses("enter", base, 1);

        // Bouncing 7, then a held press.
        base = trig_num_q.size();
        hp = int'($urandom_range(1, 4));
        for (int j = 0; j < 30; j++) begin
            pressed[8] = ((j / hp) % 2) == 0;
            tick(1);
        end
        pressed[8] = 1'b1;
        tick(60);
        pressed[8] = 1'b0;
        tick(40);
        exp_num = key_code(8);
        check_pulses("bounce7", base, 1);

        // Short glitch on 3 never emits; a later 0 proves scanning resumed.
        base = trig_num_q.size();
        g = int'($urandom_range(1, 7));
        pressed[2] = 1'b1;
        tick(g);
        pressed[2] = 1'b0;
        tick(40);
        check_pulses("glitch3", base, 0);
        chk("glitch_num_held", 32'(cmd.num), 32'(exp_num));
        tap(13, 60);
        check_pulses("after_glitch", base, 1);

        // Simultaneous 1 and 2: first column wins; 2 follows once 1 is released.
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        do_reset();
        base = trig_num_q.size();
        tick(60);
        exp_num = key_code(0);
        check_pulses("simul_first", base, 1);
        pressed[0] = 1'b0;
        tick(60);
        exp_num = key_code(1);
        check_pulses("simul_second", base, 2);
        pressed[1] = 1'b0;
        tick(40);
        check_pulses("simul_done", base, 2);

        // Reset during the debounce of 9 aborts it; a fresh scan emits once.
        pressed[10] = 1'b1;
        do_reset();
        base = trig_num_q.size();
        tick(15);
        reset = 1'b1;
        tick(1);
        chk("midreset_col",     32'(col),         32'(4'b1110));
        chk("midreset_trigger", 32'(cmd.trigger), 32'(1'b0));
        reset = 1'b0;
        rel   = cyc;
        tick(50);
        pressed[10] = 1'b0;
        tick(40);
        exp_num = key_code(10);
        check_pulses("midreset", base, 1);
        if (trig_cyc_q.size() > base) begin
            chk("midreset_latency", 32'(trig_cyc_q[base]), 32'(rel + 21));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
